// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// It sits ahead of the IF/ID register. Every cycle it looks up the fetch PC and
// returns a taken prediction and the predicted next fetch PC. Resolved branches
// coming back from EX train the table. Two free-running counters record branch
// and mispredict statistics for the debug path.
//
// Ports
//   clk          pipeline clock, all state changes on posedge
//   rst          asynchronous active-high reset
//   PCF          current fetch PC
//   PredictedF   predicted taken for PCF
//   PredictedPCF predicted next fetch PC (BTB target or PCF+4)
//   BranchE      EX holds a valid, unflushed conditional branch
//   BrTakenE     actual outcome of the EX branch
//   PCE          PC of the EX branch
//   BrTargetE    resolved taken target of the EX branch
//   PredictedE   prediction that travelled down the pipe with the EX branch
//   MispredictE  EX branch outcome differs from its prediction (combinational)
//   BranchCnt    resolved branches since reset
//   MissCnt      mispredicts since reset
// -----------------------------------------------------------------------------
module btb_predictor #(
   parameter int ENTRY_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   output logic        PredictedF,
   output logic [31:0] PredictedPCF,
   input  logic        BranchE,
   input  logic        BrTakenE,
   input  logic [31:0] PCE,
   input  logic [31:0] BrTargetE,
   input  logic        PredictedE,
   output logic        MispredictE,
   output logic [31:0] BranchCnt,
   output logic [31:0] MissCnt
);

   localparam int TAG_BITS = 30 - ENTRY_BITS;
   localparam int ENTRIES  = 1 << ENTRY_BITS;

   // Table storage. Only valid and ctr are reset; tag and target are
   // meaningless until an entry is allocated.
   logic                validQ  [ENTRIES];
   logic [TAG_BITS-1:0] tagQ    [ENTRIES];
   logic [31:0]         targetQ [ENTRIES];
   logic [1:0]          ctrQ    [ENTRIES];

   logic [31:0] branchCntQ;
   logic [31:0] missCntQ;

   logic [ENTRY_BITS-1:0] fetchIdx;
   logic [TAG_BITS-1:0]   fetchTag;
   logic                  fetchHit;

   logic [ENTRY_BITS-1:0] exIdx;
   logic [TAG_BITS-1:0]   exTag;
   logic                  exHit;
   logic [1:0]            ctrD;
   logic                  entryWrite;
   logic                  targetWrite;

   // The two low PC bits are always zero for aligned instructions and carry
   // no index or tag information.
   logic unusedPceBits;
   assign unusedPceBits = ^PCE[1:0];

   // Fetch-side lookup. Reads the registered table directly, so a same-cycle
   // update to the same index is not visible until after the edge.
   assign fetchIdx     = PCF[ENTRY_BITS+1:2];
   assign fetchTag     = PCF[31:ENTRY_BITS+2];
   assign fetchHit     = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
   assign PredictedF   = fetchHit && ctrQ[fetchIdx][1];
   assign PredictedPCF = PredictedF ? targetQ[fetchIdx] : PCF + 32'd4;

   assign MispredictE = BranchE && (PredictedE != BrTakenE);
   assign BranchCnt   = branchCntQ;
   assign MissCnt     = missCntQ;

   assign exIdx = PCE[ENTRY_BITS+1:2];
   assign exTag = PCE[31:ENTRY_BITS+2];
   assign exHit = validQ[exIdx] && (tagQ[exIdx] == exTag);

   // Next counter value for the EX entry. A hit moves the counter one step
   // toward the outcome, saturating at both ends. A taken miss allocates the
   // entry as weakly taken; a not-taken miss leaves the table untouched.
   always_comb begin
      ctrD        = ctrQ[exIdx];
      entryWrite  = BranchE && (exHit || BrTakenE);
      targetWrite = BranchE && BrTakenE;
      if (exHit) begin
         if (BrTakenE) begin
            if (ctrQ[exIdx] != 2'b11) begin
               ctrD = ctrQ[exIdx] + 2'd1;
            end
         end else if (ctrQ[exIdx] != 2'b00) begin
            ctrD = ctrQ[exIdx] - 2'd1;
         end
      end else begin
         ctrD = 2'b10;
      end
   end

   // Valid bits, counters and statistics. Reset clears them at once and
   // holds them cleared, which discards every trained entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i] <= 1'b0;
            ctrQ[i]   <= 2'b00;
         end
         branchCntQ <= 32'd0;
         missCntQ   <= 32'd0;
      end else begin
         if (entryWrite) begin
            validQ[exIdx] <= 1'b1;
            ctrQ[exIdx]   <= ctrD;
         end
         if (BranchE) begin
            branchCntQ <= branchCntQ + 32'd1;
         end
         if (MispredictE) begin
            missCntQ <= missCntQ + 32'd1;
         end
      end
   end

   // Tag and target. Every taken branch writes both: on a hit the tag is
   // unchanged and the target refreshes, on a miss this is the allocation
   // that overwrites any aliasing entry.
   always_ff @(posedge clk) begin
      if (targetWrite) begin
         tagQ[exIdx]    <= exTag;
         targetQ[exIdx] <= BrTargetE;
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_predictor
//
// Self-checking bench for btb_predictor. A small reference model of the table
// produces the expected lookup result whenever a lookup is driven; that result
// is queued and later popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_btb_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        PredictedF;
   logic [31:0] PredictedPCF;
   logic        BranchE;
   logic        BrTakenE;
   logic [31:0] PCE;
   logic [31:0] BrTargetE;
   logic        PredictedE;
   logic        MispredictE;
   logic [31:0] BranchCnt;
   logic [31:0] MissCnt;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct packed {
      logic        predF;
      logic [31:0] predPC;
      logic [31:0] brCnt;
      logic [31:0] missCnt;
   } lookupExp_t;

   lookupExp_t sbQueue[$];

   // Reference model state
   logic        mValid  [64];
   logic [23:0] mTag    [64];
   logic [31:0] mTarget [64];
   logic [1:0]  mCtr    [64];
   logic [31:0] mBranch;
   logic [31:0] mMiss;

   btb_predictor dut (
      .clk          (clk),
      .rst          (rst),
      .PCF          (PCF),
      .PredictedF   (PredictedF),
      .PredictedPCF (PredictedPCF),
      .BranchE      (BranchE),
      .BrTakenE     (BrTakenE),
      .PCE          (PCE),
      .BrTargetE    (BrTargetE),
      .PredictedE   (PredictedE),
      .MispredictE  (MispredictE),
      .BranchCnt    (BranchCnt),
      .MissCnt      (MissCnt)
   );

   // 10-time-unit clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void modelReset();
      for (int i = 0; i < 64; i++) begin
         mValid[i] = 1'b0;
         mCtr[i]   = 2'b00;
      end
      mBranch = 32'd0;
      mMiss   = 32'd0;
   endfunction

   function automatic lookupExp_t modelLookup(input logic [31:0] pc);
      lookupExp_t r;
      logic       hit;
      hit       = mValid[pc[7:2]] && (mTag[pc[7:2]] == pc[31:8]);
      r.predF   = hit && (mCtr[pc[7:2]] >= 2'd2);
      r.predPC  = r.predF ? mTarget[pc[7:2]] : pc + 32'd4;
      r.brCnt   = mBranch;
      r.missCnt = mMiss;
      return r;
   endfunction

   function automatic void modelUpdate(input logic [31:0] pc, input logic taken,
                                       input logic [31:0] target, input logic pe);
      int  idx;
      logic hit;
      idx = int'(pc[7:2]);
      hit = mValid[idx] && (mTag[idx] == pc[31:8]);
      mBranch = mBranch + 32'd1;
      if (pe != taken) mMiss = mMiss + 32'd1;
      if (hit) begin
         if (taken) begin
            if (mCtr[idx] < 2'd3) mCtr[idx] = mCtr[idx] + 2'd1;
            mTarget[idx] = target;
         end else if (mCtr[idx] > 2'd0) begin
            mCtr[idx] = mCtr[idx] - 2'd1;
         end
      end else if (taken) begin
         mValid[idx]  = 1'b1;
         mTag[idx]    = pc[31:8];
         mTarget[idx] = target;
         mCtr[idx]    = 2'b10;
      end
   endfunction

   // Presents a resolved EX branch at the falling edge and lets the
   // combinational outputs settle.
   task automatic applyStimulus(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic pe);
      @(negedge clk);
      BranchE    = 1'b1;
      PCE        = pc;
      BrTakenE   = taken;
      BrTargetE  = target;
      PredictedE = pe;
      #1;
   endtask

   // Lets the pending branch be captured at the next posedge and mirrors it in
   // the model, then withdraws BranchE so it is seen for exactly one edge.
   task automatic clockBranch();
      @(posedge clk);
      modelUpdate(PCE, BrTakenE, BrTargetE, PredictedE);
      #1;
      BranchE = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] pcs[3];
      lookupExp_t  e;
      pcs[0] = 32'h0000_0100;
      pcs[1] = 32'hFFFF_FFFC;
      pcs[2] = 32'h0000_0040;
      rst = 1'b1;
      modelReset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         PCF = pcs[k];
         sbQueue.push_back(modelLookup(pcs[k]));
         #1;
         e = sbQueue.pop_front();
         assertCount += 4;
         if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL reset_predF pc=%h got %b want %b", pcs[k], PredictedF, e.predF); end
         if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL reset_predPC pc=%h got %h want %h", pcs[k], PredictedPCF, e.predPC); end
         if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL reset_branchCnt got %0d want %0d", BranchCnt, e.brCnt); end
         if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL reset_missCnt got %0d want %0d", MissCnt, e.missCnt); end
      end
   endtask

   task automatic test_allocate_hit();
      lookupExp_t e;
      applyStimulus(32'h40, 1'b1, 32'h80, 1'b0);
      assertCount++;
      if (MispredictE !== 1'b1) begin failCount++; $display("[TB] FAIL alloc_mispredict got %b want 1", MispredictE); end
      clockBranch();
      PCF = 32'h40;
      sbQueue.push_back(modelLookup(32'h40));
      #1;
      e = sbQueue.pop_front();
      assertCount += 4;
      if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL alloc_predF got %b want %b", PredictedF, e.predF); end
      if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL alloc_predPC got %h want %h", PredictedPCF, e.predPC); end
      if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL alloc_branchCnt got %0d want %0d", BranchCnt, e.brCnt); end
      if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL alloc_missCnt got %0d want %0d", MissCnt, e.missCnt); end
   endtask

   task automatic test_hysteresis();
      logic [0:9] takenSeq;
      logic [0:9] predSeq;
      logic       pe;
      lookupExp_t e;
      takenSeq = 10'b0001111110;
      predSeq  = 10'b0000111111;
      for (int i = 0; i < 10; i++) begin
         pe = modelLookup(32'h40).predF;
         applyStimulus(32'h40, takenSeq[i], 32'h80, pe);
         assertCount++;
         if (MispredictE !== (pe ^ takenSeq[i])) begin failCount++; $display("[TB] FAIL hyst_mispredict step=%0d got %b want %b", i, MispredictE, pe ^ takenSeq[i]); end
         clockBranch();
         PCF = 32'h40;
         sbQueue.push_back(modelLookup(32'h40));
         #1;
         e = sbQueue.pop_front();
         assertCount += 5;
         if (PredictedF !== predSeq[i]) begin failCount++; $display("[TB] FAIL hyst_seq step=%0d got %b want %b", i, PredictedF, predSeq[i]); end
         if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL hyst_predF step=%0d got %b want %b", i, PredictedF, e.predF); end
         if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL hyst_predPC step=%0d got %h want %h", i, PredictedPCF, e.predPC); end
         if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL hyst_branchCnt step=%0d got %0d want %0d", i, BranchCnt, e.brCnt); end
         if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL hyst_missCnt step=%0d got %0d want %0d", i, MissCnt, e.missCnt); end
      end
   endtask

   task automatic test_not_taken_miss();
      lookupExp_t e;
      applyStimulus(32'h200, 1'b0, 32'h300, 1'b0);
      assertCount++;
      if (MispredictE !== 1'b0) begin failCount++; $display("[TB] FAIL ntmiss_mispredict got %b want 0", MispredictE); end
      clockBranch();
      PCF = 32'h200;
      sbQueue.push_back(modelLookup(32'h200));
      #1;
      e = sbQueue.pop_front();
      assertCount += 4;
      if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL ntmiss_predF got %b want %b", PredictedF, e.predF); end
      if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL ntmiss_predPC got %h want %h", PredictedPCF, e.predPC); end
      if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL ntmiss_branchCnt got %0d want %0d", BranchCnt, e.brCnt); end
      if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL ntmiss_missCnt got %0d want %0d", MissCnt, e.missCnt); end
   endtask

   task automatic test_aliasing();
      logic [31:0] pcs[5];
      lookupExp_t  e;
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'h40, 1'b1, 32'h80, 1'b0);
      clockBranch();
      applyStimulus(32'h140, 1'b1, 32'h1C0, 1'b0);
      clockBranch();
      // Lookups 0-1 after aliasing, 2 in the same cycle as an update to 0x40,
      // 3-4 after that update has been captured.
      pcs[0] = 32'h140;
      pcs[1] = 32'h40;
      pcs[2] = 32'h40;
      pcs[3] = 32'h40;
      pcs[4] = 32'h140;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) applyStimulus(32'h40, 1'b1, 32'h90, 1'b0);
         if (k == 3) clockBranch();
         PCF = pcs[k];
         sbQueue.push_back(modelLookup(pcs[k]));
         #1;
         e = sbQueue.pop_front();
         assertCount += 4;
         if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL alias_predF k=%0d pc=%h got %b want %b", k, pcs[k], PredictedF, e.predF); end
         if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL alias_predPC k=%0d pc=%h got %h want %h", k, pcs[k], PredictedPCF, e.predPC); end
         if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL alias_branchCnt k=%0d got %0d want %0d", k, BranchCnt, e.brCnt); end
         if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL alias_missCnt k=%0d got %0d want %0d", k, MissCnt, e.missCnt); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      logic        taken;
      logic        pe;
      lookupExp_t  e;
      for (int i = 0; i < 24; i++) begin
         pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(1, 4)) << 2);
         taken = 1'($urandom_range(0, 1));
         pe    = 1'($urandom_range(0, 1));
         applyStimulus(pc, taken, $urandom & 32'hFFFF_FFFC, pe);
         assertCount++;
         if (MispredictE !== (pe ^ taken)) begin failCount++; $display("[TB] FAIL b2b_mispredict i=%0d got %b want %b", i, MispredictE, pe ^ taken); end
         clockBranch();
      end
      for (int t = 0; t < 4; t++) begin
         for (int x = 1; x <= 4; x++) begin
            pc  = (32'(t) << 8) | (32'(x) << 2);
            PCF = pc;
            sbQueue.push_back(modelLookup(pc));
            #1;
            e = sbQueue.pop_front();
            assertCount += 4;
            if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL b2b_predF pc=%h got %b want %b", pc, PredictedF, e.predF); end
            if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL b2b_predPC pc=%h got %h want %h", pc, PredictedPCF, e.predPC); end
            if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL b2b_branchCnt got %0d want %0d", BranchCnt, e.brCnt); end
            if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL b2b_missCnt got %0d want %0d", MissCnt, e.missCnt); end
         end
      end
   endtask

   task automatic test_async_reset();
      lookupExp_t e;
      applyStimulus(32'h44, 1'b1, 32'h1000, 1'b0);
      clockBranch();
      // Step 0: trained entry before reset. Step 1: reset asserted between
      // edges. Step 2: first update after reset is accepted.
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            @(negedge clk);
            #2;
            rst = 1'b1;
            modelReset();
         end
         if (k == 2) begin
            @(negedge clk);
            rst = 1'b0;
            applyStimulus(32'h44, 1'b1, 32'h2000, 1'b0);
            clockBranch();
         end
         PCF = 32'h44;
         sbQueue.push_back(modelLookup(32'h44));
         #1;
         e = sbQueue.pop_front();
         assertCount += 4;
         if (PredictedF !== e.predF) begin failCount++; $display("[TB] FAIL arst_predF k=%0d got %b want %b", k, PredictedF, e.predF); end
         if (PredictedPCF !== e.predPC) begin failCount++; $display("[TB] FAIL arst_predPC k=%0d got %h want %h", k, PredictedPCF, e.predPC); end
         if (BranchCnt !== e.brCnt) begin failCount++; $display("[TB] FAIL arst_branchCnt k=%0d got %0d want %0d", k, BranchCnt, e.brCnt); end
         if (MissCnt !== e.missCnt) begin failCount++; $display("[TB] FAIL arst_missCnt k=%0d got %0d want %0d", k, MissCnt, e.missCnt); end
      end
   endtask

   initial begin
      rst        = 1'b1;
      PCF        = 32'd0;
      BranchE    = 1'b0;
      BrTakenE   = 1'b0;
      PCE        = 32'd0;
      BrTargetE  = 32'd0;
      PredictedE = 1'b0;
      modelReset();
      test_reset();
      test_allocate_hit();
      test_hysteresis();
      test_not_taken_miss();
      test_aliasing();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
